// File: rtl/agc_gain_ctrl.sv
// Window-peak AGC gain controller: tracks the peak |sample| over 2^WIN_LOG2 accepted samples and steps the gain code.
// Optional macro AGC_HYST_EN enables the +/-HYST deadband around target; without it the deadband is zero.
module agc_gain_ctrl #(
    parameter int WIN_LOG2    = 4,
    parameter int GAIN_INIT   = 32,
    parameter int ATTACK_STEP = 4,
    parameter int HYST        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_enable,
    input  logic signed [7:0] sample_in,
    input  logic              sample_valid,
    input  logic [6:0]        target,
    output logic [5:0]        gain,
    output logic              gain_valid,
    output logic              busy,
    output logic              sat
);

    localparam int            CW       = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << WIN_LOG2) - 1);
`ifdef AGC_HYST_EN
    localparam bit            HYST_ON  = 1'b1;
`else
    localparam bit            HYST_ON  = 1'b0;
`endif
    localparam logic [7:0]    BAND     = HYST_ON ? 8'(HYST) : 8'd0;
    localparam logic [5:0]    STEP     = 6'(ATTACK_STEP);
    localparam logic [5:0]    G_INIT   = 6'(GAIN_INIT);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [6:0]    peak;
    logic [5:0]    gain_q, gain_calc;
    logic          sat_q;
    logic [7:0]    abs_val;
    logic [6:0]    mag;
    logic [7:0]    thr_hi, thr_lo;
    logic          accept, last_accept;

    // Only -128 overflows the 7-bit magnitude, so it saturates to 127.
    assign abs_val     = sample_in[7] ? (~sample_in + 8'd1) : sample_in;
    assign mag         = abs_val[7] ? 7'h7F : abs_val[6:0];
    assign accept      = clk_enable && sample_valid && !busy;
    assign last_accept = accept && (count == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clk_enable) begin
            case (state)
                IDLE, ACCUM: begin
                    if (last_accept)
                        state_next = DECIDE;
                    else if (accept)
                        state_next = ACCUM;
                end
                DECIDE:  state_next = UPDATE;
                UPDATE:  state_next = ACCUM;
                default: state_next = IDLE;
            endcase
        end
    end

    // Thresholds carry an extra bit so target+BAND cannot wrap; the lower one floors at 0.
    always_comb begin
        thr_hi    = {1'b0, target} + BAND;
        thr_lo    = ({1'b0, target} > BAND) ? ({1'b0, target} - BAND) : 8'd0;
        gain_calc = gain_q;
        if ({1'b0, peak} > thr_hi)
            gain_calc = (gain_q > STEP) ? (gain_q - STEP) : 6'd0;
        else if ({1'b0, peak} < thr_lo)
            gain_calc = (gain_q == 6'd63) ? gain_q : (gain_q + 6'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            peak   <= '0;
            gain_q <= G_INIT;
            sat_q  <= 1'b0;
        end else if (clk_enable) begin
            if (state == DECIDE) begin
                gain_q <= gain_calc;
                sat_q  <= (gain_calc == 6'd0) || (gain_calc == 6'd63);
                count  <= '0;
                peak   <= '0;
            end else if (accept) begin
                count <= count + 1'b1;
                if (mag > peak)
                    peak <= mag;
            end
        end
    end

    always_comb begin
        busy       = 1'b0;
        gain_valid = 1'b0;
        case (state)
            DECIDE:  busy = 1'b1;
            UPDATE: begin
                busy       = 1'b1;
                gain_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign gain = gain_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Scoreboard bench for agc_gain_ctrl: a reference model predicts each window decision, a monitor checks every gain_valid pulse.
// Honours AGC_HYST_EN the same way as the design.
module tb_agc_gain_ctrl;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_enable = 1'b1;
    logic signed [7:0] sample_in = 8'sd0;
    logic              sample_valid = 1'b0;
    logic [6:0]        target = 7'd64;
    logic [5:0]        gain;
    logic              gain_valid, busy, sat;

`ifdef AGC_HYST_EN
    localparam int TB_BAND  = 4;
    localparam int EXP_BAND = 32;
`else
    localparam int TB_BAND  = 0;
    localparam int EXP_BAND = 28;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int m_gain = 32, m_cnt = 0, m_peak = 0, m_busy = 0;
    int mon_exp;
    logic prev_gv = 1'b0;

    agc_gain_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
        .sample_in(sample_in), .sample_valid(sample_valid), .target(target),
        .gain(gain), .gain_valid(gain_valid), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic int model_next(input int g, input int pk, input int tgt);
        int lo;
        lo = tgt - TB_BAND;
        if (lo < 0) lo = 0;
        if (pk > tgt + TB_BAND) return (g - 4 < 0) ? 0 : g - 4;
        if (pk < lo) return (g + 1 > 63) ? 63 : g + 1;
        return g;
    endfunction

    function automatic int mag_of(input logic signed [7:0] v);
        int x;
        x = int'(v);
        if (x < 0) x = -x;
        if (x > 127) x = 127;
        return x;
    endfunction

    // Drives one cycle of inputs and advances the reference model alongside.
    task automatic tick(input logic signed [7:0] v, input logic vld, input logic en);
        @(negedge clk);
        sample_in = v;
        sample_valid = vld;
        clk_enable = en;
        if (en && rst_n) begin
            if (m_busy > 0)
                m_busy--;
            else if (vld) begin
                m_cnt++;
                if (mag_of(v) > m_peak) m_peak = mag_of(v);
                if (m_cnt == 16) begin
                    m_gain = model_next(m_gain, m_peak, int'(target));
                    exp_q.push_back(m_gain);
                    m_cnt = 0;
                    m_peak = 0;
                    m_busy = 2;
                end
            end
        end
    endtask

    task automatic window(input logic signed [7:0] v);
        repeat (16) tick(v, 1'b1, 1'b1);
        tick(8'sd0, 1'b0, 1'b1);
        tick(8'sd0, 1'b0, 1'b1);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        clk_enable = 1'b1;
        m_gain = 32; m_cnt = 0; m_peak = 0; m_busy = 0;
        exp_q.delete();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (gain_valid && !prev_gv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_gain_valid: got pulse with gain %0d, required no pulse", gain);
            end else begin
                mon_exp = exp_q.pop_front();
                if (gain !== 6'(mon_exp)) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_gain: got %0d required %0d", gain, mon_exp);
                end
            end
        end
        prev_gv = gain_valid;
    end

    task automatic test_reset();
        assert_reset();
        checks += 4;
        if (gain !== 6'd32) begin errors++; $display("[TB] FAIL reset_gain: got %0d required 32", gain); end
        if (gain_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_gain_valid: got %b required 0", gain_valid); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        if (sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %b required 0", sat); end
        release_reset();
    endtask

    task automatic test_attack();
        target = 7'd64;
        repeat (16) tick(8'sd100, 1'b1, 1'b1);
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL decide_busy: got %b required 1", busy); end
        if (gain_valid !== 1'b0) begin errors++; $display("[TB] FAIL decide_gain_valid: got %b required 0", gain_valid); end
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain_valid !== 1'b1) begin errors++; $display("[TB] FAIL attack_gain_valid: got %b required 1", gain_valid); end
        if (gain !== 6'd28) begin errors++; $display("[TB] FAIL attack_gain: got %0d required 28", gain); end
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain_valid !== 1'b0) begin errors++; $display("[TB] FAIL pulse_width: got %b required 0", gain_valid); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_update_busy: got %b required 0", busy); end
    endtask

    task automatic test_deadband();
        assert_reset();
        release_reset();
        target = 7'd125;
        window(-8'sd128);
        checks += 2;
        if (gain_valid !== 1'b1) begin errors++; $display("[TB] FAIL band_gain_valid: got %b required 1", gain_valid); end
        if (gain !== 6'(EXP_BAND)) begin errors++; $display("[TB] FAIL band_gain: got %0d required %0d", gain, EXP_BAND); end
        tick(8'sd0, 1'b0, 1'b1);
    endtask

    task automatic test_release_sat();
        assert_reset();
        release_reset();
        target = 7'd64;
        repeat (40) window(8'sd10);
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain !== 6'd63) begin errors++; $display("[TB] FAIL release_cap_gain: got %0d required 63", gain); end
        if (sat !== 1'b1) begin errors++; $display("[TB] FAIL release_cap_sat: got %b required 1", sat); end
        repeat (16) window(8'sd127);
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain !== 6'd0) begin errors++; $display("[TB] FAIL attack_floor_gain: got %0d required 0", gain); end
        if (sat !== 1'b1) begin errors++; $display("[TB] FAIL attack_floor_sat: got %b required 1", sat); end
        repeat (2) window(8'sd10);
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain !== 6'd2) begin errors++; $display("[TB] FAIL climb_gain: got %0d required 2", gain); end
        if (sat !== 1'b0) begin errors++; $display("[TB] FAIL climb_sat: got %b required 0", sat); end
        window(8'sd127);
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain !== 6'd0) begin errors++; $display("[TB] FAIL gain2_floor: got %0d required 0", gain); end
        if (sat !== 1'b1) begin errors++; $display("[TB] FAIL gain2_floor_sat: got %b required 1", sat); end
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] v;
        assert_reset();
        release_reset();
        target = 7'd64;
        for (int i = 0; i < 34; i++) begin
            v = (i < 16) ? 8'sd100 : (i < 18) ? -8'sd128 : 8'sd50;
            tick(v, 1'b1, 1'b1);
        end
        tick(8'sd0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_decide_busy: got %b required 1", busy); end
        tick(8'sd0, 1'b0, 1'b1);
        checks += 2;
        if (gain_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gain_valid: got %b required 1", gain_valid); end
        if (gain !== 6'd29) begin errors++; $display("[TB] FAIL b2b_gain: got %0d required 29", gain); end
        tick(8'sd0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        assert_reset();
        release_reset();
        target = 7'd64;
        repeat (8) tick(8'sd20, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(-8'sd128, 1'b1, 1'b0);
            checks++;
            if (busy !== 1'b0 || gain_valid !== 1'b0 || gain !== 6'd32) begin
                errors++;
                $display("[TB] FAIL stall_hold: got busy %b gv %b gain %0d required 0 0 32", busy, gain_valid, gain);
            end
        end
        repeat (8) tick(8'sd20, 1'b1, 1'b1);
        tick(8'sd0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_decide_busy: got %b required 1", busy); end
        for (int i = 0; i < 5; i++) begin
            tick(8'sd0, 1'b0, (i == 4));
            checks++;
            if (gain_valid !== 1'b1 || gain !== 6'd33) begin
                errors++;
                $display("[TB] FAIL stall_update_hold: got gv %b gain %0d required 1 33", gain_valid, gain);
            end
        end
        tick(8'sd0, 1'b0, 1'b1);
        checks++;
        if (gain_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_update_end: got %b required 0", gain_valid); end
    endtask

    task automatic test_reset_mid();
        repeat (10) tick(8'sd30, 1'b1, 1'b1);
        assert_reset();
        checks += 2;
        if (gain !== 6'd32) begin errors++; $display("[TB] FAIL midreset_gain: got %0d required 32", gain); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b required 0", busy); end
        release_reset();
        repeat (20) tick(8'sd0, 1'b0, 1'b1);
        repeat (16) tick(8'sd127, 1'b1, 1'b1);
        tick(8'sd0, 1'b0, 1'b1);
        assert_reset();
        checks += 2;
        if (gain !== 6'd32) begin errors++; $display("[TB] FAIL decide_reset_gain: got %0d required 32", gain); end
        if (gain_valid !== 1'b0) begin errors++; $display("[TB] FAIL decide_reset_gv: got %b required 0", gain_valid); end
        release_reset();
        repeat (10) tick(8'sd0, 1'b0, 1'b1);
        target = 7'd64;
        window(8'sd30);
        checks += 2;
        if (gain_valid !== 1'b1) begin errors++; $display("[TB] FAIL postreset_gv: got %b required 1", gain_valid); end
        if (gain !== 6'd33) begin errors++; $display("[TB] FAIL postreset_gain: got %0d required 33", gain); end
        tick(8'sd0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_attack();
        test_deadband();
        test_release_sat();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        repeat (4) tick(8'sd0, 1'b0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_decisions: got %0d outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/agc_gain_ctrl.md
AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 4, log2 of the window length in accepted samples (window = 16).
REQ-002 SHALL have parameter GAIN_INIT, default 32, gain code after reset.
REQ-003 SHALL have parameter ATTACK_STEP, default 4, gain decrement per attack decision.
REQ-004 SHALL have parameter HYST, default 4, deadband half-width in magnitude LSBs.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clk_enable, input, 1, global advance enable; when low, all state holds.
REQ-008 SHALL have port sample_in, input, 8, signed two's-complement sample from the AGC datapath.
REQ-009 SHALL have port sample_valid, input, 1, sample_in is valid this cycle.
REQ-010 SHALL have port target, input, 7, unsigned target peak magnitude (0..127).
REQ-011 SHALL have port gain, output, 6, unsigned gain code driven to the AGC datapath.
REQ-012 SHALL have port gain_valid, output, 1, one-cycle pulse when a window decision is applied.
REQ-013 SHALL have port busy, output, 1, high in DECIDE and UPDATE; samples are not accepted while high.
REQ-014 SHALL have port sat, output, 1, high while gain == 0 or gain == 63.

Function
REQ-015 SHALL accept a sample only when clk_enable && sample_valid && !busy.
REQ-016 SHALL compute magnitude as |sample_in|, with -128 saturating to 127.
REQ-017 SHALL implement states IDLE, ACCUM, DECIDE and UPDATE.
REQ-018 SHALL move IDLE->ACCUM on the first accepted sample, which counts as window sample 1.
REQ-019 SHALL, in ACCUM, track peak = max(magnitude) and count accepted samples; on the edge accepting sample 2^WIN_LOG2, go to DECIDE.
REQ-020 SHALL, in DECIDE, sample target and compute the next gain from the window peak; at the end of the DECIDE cycle, load gain, go to UPDATE, and clear peak and count.
REQ-021 SHALL apply attack when peak > target+HYST: gain -= ATTACK_STEP, floored at 0.
REQ-022 SHALL apply release when peak < target-HYST: gain += 1, capped at 63.
REQ-023 SHALL otherwise hold gain, and still pulse gain_valid.
REQ-024 SHALL evaluate target+HYST and target-HYST with 8-bit headroom, with target-HYST floored at 0 and no wrap-around.
REQ-025 SHALL assert gain_valid for exactly the UPDATE cycle, then return to ACCUM.
REQ-026 SHALL give a latency of 2 clk_enable cycles from the edge accepting the last window sample to gain/gain_valid becoming visible.
REQ-027 SHALL ignore sample_valid while busy; those samples are not counted and not peaked.
REQ-028 SHALL, with clk_enable low in any state, freeze state, count, peak and gain; a gain_valid pulse held across a stall SHALL stay high until UPDATE completes.
REQ-029 SHALL register sat from the gain register, with no combinational path from inputs.

Reset
REQ-030 SHALL on rst_n low immediately set state=IDLE, count=0, peak=0, gain=GAIN_INIT, gain_valid=0, busy=0, sat=0 (GAIN_INIT not in {0,63}).
REQ-031 SHALL, on reset mid-window or mid-DECIDE, discard the partial window with no gain update.
REQ-032 SHALL deassert reset synchronously to clk; the first acceptance SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-033 SHALL, with macro AGC_HYST_EN defined, use the HYST deadband per REQ-021..023.
REQ-034 SHALL, without AGC_HYST_EN, treat the deadband as 0: peak > target gives attack, peak < target gives release, peak == target holds; HYST is unused.

Verification
REQ-035 SHALL cover: reset asserted -> gain=32, gain_valid=0, busy=0, sat=0; 16 samples of +100 with target=64 -> gain=28 with a one-cycle gain_valid 2 cycles after the 16th accept.
REQ-036 SHALL cover: 16 samples of -128 with target=125 -> peak 127 is within the band, gain unchanged at 32, gain_valid still pulses (without AGC_HYST_EN -> attack, gain=28).
REQ-037 SHALL cover: 40 windows of +10 with target=64 from 32 -> gain climbs by 1 per window, stops at 63, sat=1; 16 samples of +127 at gain 2 -> gain=0, sat=1.
REQ-038 SHALL cover: sample_valid held high through DECIDE/UPDATE -> those 2 samples are not counted, and the next decision fires after 16 further accepts.
REQ-039 SHALL cover: clk_enable low for 5 cycles at count 8 -> no state change, and the window completes after 8 more accepts; rst_n pulsed at count 10 -> gain=32, with no gain_valid from the aborted window.
